// File: rtl/ov7670_dvp_tx.sv
// OV7670-style DVP transmitter: reads a frame buffer and replays it as pclk/href/vsync/data
// in RGB444 (two bytes per pixel) or YUV422 gray, for camera-less loopback of the capture path.
module ov7670_dvp_tx #(
    parameter int c_img_cols     = 80,
    parameter int c_img_rows     = 60,
    parameter int c_nb_line_pxls = 7,
    parameter int c_nb_img_pxls  = 13,
    parameter int c_nb_buf       = 12,
    parameter int c_pclk_div     = 4,
    parameter int c_vsync_pclks  = 8,
    parameter int c_vbp_pclks    = 4,
    parameter int c_hblank_pclks = 16,
    parameter int c_vfp_pclks    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     rgbmode,
    input  logic                     swap_r_b,
    input  logic [c_nb_buf-1:0]      din,
    output logic [c_nb_img_pxls-1:0] addr,
    output logic                     pclk,
    output logic                     href,
    output logic                     vsync,
    output logic [7:0]               data,
    output logic                     frame_done
);
    localparam int c_half   = c_pclk_div / 2;
    localparam int c_div_w  = $clog2(c_pclk_div);
    localparam int c_m1     = (c_vsync_pclks > c_vbp_pclks) ? c_vsync_pclks : c_vbp_pclks;
    localparam int c_m2     = (c_hblank_pclks > c_vfp_pclks) ? c_hblank_pclks : c_vfp_pclks;
    localparam int c_cnt_w  = $clog2(((c_m1 > c_m2) ? c_m1 : c_m2) + 1);
    localparam int c_col_w  = c_nb_line_pxls + 1;
    localparam int c_row_w  = (c_img_rows > 1) ? $clog2(c_img_rows) : 1;

    localparam logic [c_div_w-1:0]        c_div_last  = c_div_w'(c_pclk_div - 1);
    localparam logic [c_div_w-1:0]        c_div_rise  = c_div_w'(c_half - 1);
    localparam logic [c_cnt_w-1:0]        c_vs_last   = c_cnt_w'(c_vsync_pclks - 1);
    localparam logic [c_cnt_w-1:0]        c_vbp_last  = c_cnt_w'(c_vbp_pclks - 1);
    localparam logic [c_cnt_w-1:0]        c_hb_last   = c_cnt_w'(c_hblank_pclks - 1);
    localparam logic [c_cnt_w-1:0]        c_hb_pre    = c_cnt_w'(c_hblank_pclks - 2);
    localparam logic [c_cnt_w-1:0]        c_vfp_last  = c_cnt_w'(c_vfp_pclks - 1);
    localparam logic [c_col_w-1:0]        c_byte_last = c_col_w'(2 * c_img_cols - 1);
    localparam logic [c_nb_line_pxls-1:0] c_pix_last  = c_nb_line_pxls'(c_img_cols - 1);
    localparam logic [c_row_w-1:0]        c_row_last  = c_row_w'(c_img_rows - 1);

    typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_LINE, S_HBLANK, S_VFP} t_state;

    t_state                   r_state;
    logic [c_div_w-1:0]       r_div;
    logic [c_cnt_w-1:0]       r_cnt;
    logic [c_col_w-1:0]       r_col;
    logic [c_row_w-1:0]       r_row;
    logic [c_nb_img_pxls-1:0] r_addr;
    logic                     r_pclk, r_href, r_vsync, r_frame_done;
    logic [7:0]               r_data;
    logic                     r_rgb, r_swap;
    logic [c_nb_buf-1:0]      r_pix;
    logic                     w_tick;

    function automatic logic [7:0] f_byte0(input logic [c_nb_buf-1:0] pix, input logic rgb,
                                           input logic swap);
        if (!rgb) return pix[7:0];
        return {4'h0, swap ? pix[3:0] : pix[11:8]};
    endfunction

    function automatic logic [7:0] f_byte1(input logic [c_nb_buf-1:0] pix, input logic rgb,
                                           input logic swap);
        if (!rgb) return 8'h80;
        return {pix[7:4], swap ? pix[11:8] : pix[3:0]};
    endfunction

    // Tick boundary: the clk edge on which pclk falls and all video outputs advance.
    assign w_tick = (r_div == c_div_last);

    // Memory read data arrives one clk after addr; the pixel is consumed a full tick later.
    always_ff @(posedge clk) begin
        r_pix <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_div        <= '0;
            r_cnt        <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_addr       <= '0;
            r_pclk       <= 1'b0;
            r_href       <= 1'b0;
            r_vsync      <= 1'b0;
            r_data       <= 8'h00;
            r_frame_done <= 1'b0;
            r_rgb        <= 1'b0;
            r_swap       <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_tick) begin
                r_div  <= '0;
                r_pclk <= 1'b0;
            end else begin
                r_div <= r_div + 1'b1;
                if (r_div == c_div_rise) r_pclk <= 1'b1;
            end

            if (w_tick) begin
                case (r_state)
                    S_IDLE: begin
                        if (enable) begin
                            r_rgb   <= rgbmode;
                            r_swap  <= swap_r_b;
                            r_vsync <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= S_VSYNC;
                        end
                    end
                    S_VSYNC: begin
                        if (r_cnt == c_vs_last) begin
                            r_vsync <= 1'b0;
                            r_cnt   <= '0;
                            r_state <= S_VBP;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_VBP: begin
                        if (r_cnt == c_vbp_last) begin
                            r_cnt   <= '0;
                            r_col   <= '0;
                            r_href  <= 1'b1;
                            r_data  <= f_byte0(r_pix, r_rgb, r_swap);
                            r_state <= S_LINE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_LINE: begin
                        if (r_col == c_byte_last) begin
                            r_href  <= 1'b0;
                            r_data  <= 8'h00;
                            r_cnt   <= '0;
                            r_state <= S_HBLANK;
                            if (c_hblank_pclks == 1 && r_row != c_row_last) r_addr <= r_addr + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                            if (!r_col[0]) begin
                                // Byte 1 goes out while the next pixel is fetched.
                                r_data <= f_byte1(r_pix, r_rgb, r_swap);
                                if (r_col[c_col_w-1:1] != c_pix_last) r_addr <= r_addr + 1'b1;
                            end else begin
                                r_data <= f_byte0(r_pix, r_rgb, r_swap);
                            end
                        end
                    end
                    S_HBLANK: begin
                        if (r_cnt == c_hb_last) begin
                            r_cnt <= '0;
                            if (r_row == c_row_last) begin
                                r_row   <= '0;
                                r_addr  <= '0;
                                r_state <= S_VFP;
                            end else begin
                                r_row   <= r_row + 1'b1;
                                r_col   <= '0;
                                r_href  <= 1'b1;
                                r_data  <= f_byte0(r_pix, r_rgb, r_swap);
                                r_state <= S_LINE;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                            if (c_hblank_pclks > 1 && r_cnt == c_hb_pre && r_row != c_row_last)
                                r_addr <= r_addr + 1'b1;
                        end
                    end
                    S_VFP: begin
                        if (r_cnt == c_vfp_last) begin
                            r_cnt        <= '0;
                            r_frame_done <= 1'b1;
                            if (enable) begin
                                r_rgb   <= rgbmode;
                                r_swap  <= swap_r_b;
                                r_vsync <= 1'b1;
                                r_state <= S_VSYNC;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign addr       = r_addr;
    assign pclk       = r_pclk;
    assign href       = r_href;
    assign vsync      = r_vsync;
    assign data       = r_data;
    assign frame_done = r_frame_done;
endmodule

// File: tb/tb_ov7670_dvp_tx.sv
// Directed bench for ov7670_dvp_tx on a reduced 8x6 frame; the bench acts as the capture side
// and checks timing, byte packing, mode latching, enable drop and mid-frame reset.
module tb_ov7670_dvp_tx;
    localparam int COLS       = 8;
    localparam int ROWS       = 6;
    localparam int NPIX       = COLS * ROWS;
    localparam int LINE_BYTES = 2 * COLS;
    // (8 vsync + 4 vbp + 6*(16+16) + 4 vfp) ticks * 4 clk
    localparam int FRAME_CLK  = 832;

    logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, rgbmode = 1'b0, swap_r_b = 1'b0;
    logic [11:0] din;
    logic [5:0]  addr;
    logic        pclk, href, vsync, frame_done;
    logic [7:0]  data;
    logic [11:0] mem [0:63];

    int checks = 0, errors = 0;
    int bad;

    ov7670_dvp_tx #(
        .c_img_cols(COLS), .c_img_rows(ROWS), .c_nb_line_pxls(3), .c_nb_img_pxls(6),
        .c_nb_buf(12), .c_pclk_div(4), .c_vsync_pclks(8), .c_vbp_pclks(4),
        .c_hblank_pclks(16), .c_vfp_pclks(4)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .rgbmode(rgbmode), .swap_r_b(swap_r_b),
        .din(din), .addr(addr), .pclk(pclk), .href(href), .vsync(vsync), .data(data),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) din <= mem[addr];

    // Capture-side monitor, sampled on the falling clk edge.
    logic mon_clr = 1'b0;
    logic pclk_q = 1'b0, vsync_q = 1'b0;
    logic [7:0] bytes_q[$];
    int lines_q[$], gaps_q[$], vs_w_q[$];
    int cyc = 0, line_len = 0, gap_len = 0, vs_len = 0, vs_rises = 0, vs_start_cyc = 0;
    int fd_cnt = 0, fd_cyc = 0, per = 0, per_min = 1000, per_max = 0, last_rise = -1;
    int nz_cnt = 0, max_addr = 0;

    always @(negedge clk) begin
        cyc++;
        if (mon_clr) begin
            bytes_q.delete(); lines_q.delete(); gaps_q.delete(); vs_w_q.delete();
            line_len = 0; gap_len = 0; vs_len = 0; vs_rises = 0; vs_start_cyc = 0;
            fd_cnt = 0; fd_cyc = 0; per_min = 1000; per_max = 0; last_rise = -1;
            nz_cnt = 0; max_addr = 0;
        end else begin
            if (pclk === 1'b1 && pclk_q === 1'b0) begin
                if (last_rise >= 0) begin
                    per = cyc - last_rise;
                    if (per < per_min) per_min = per;
                    if (per > per_max) per_max = per;
                end
                last_rise = cyc;
                if (href) begin
                    if (gap_len > 0) begin gaps_q.push_back(gap_len); gap_len = 0; end
                    bytes_q.push_back(data);
                    line_len++;
                end else if (line_len > 0) begin
                    lines_q.push_back(line_len); line_len = 0; gap_len = 1;
                end else if (gap_len > 0) begin
                    gap_len++;
                end
            end
            if (href === 1'b0 && data !== 8'h00) nz_cnt++;
            if (vsync === 1'b1) vs_len++;
            else if (vs_len > 0) begin vs_w_q.push_back(vs_len); vs_len = 0; end
            if (vsync === 1'b1 && vsync_q === 1'b0) begin
                vs_rises++;
                if (vs_rises == 1) vs_start_cyc = cyc;
            end
            if (frame_done === 1'b1) begin fd_cnt++; fd_cyc = cyc; end
            if (int'(addr) > max_addr) max_addr = int'(addr);
        end
        pclk_q  = pclk;
        vsync_q = vsync;
    end

    task automatic mon_clear();
        mon_clr = 1'b1;
        @(negedge clk); #1;
        mon_clr = 1'b0;
    endtask

    task automatic wait_vs(input int limit);
        int n = 0;
        while (vs_rises < 1 && n < limit) begin @(negedge clk); #1; n++; end
        checks++;
        if (vs_rises < 1) begin
            errors++; $display("FAIL wait_vsync: saw %0d vsync rises, required >= 1 within %0d clk", vs_rises, limit);
        end
    endtask

    task automatic wait_fd(input int limit);
        int n = 0;
        while (fd_cnt < 1 && n < limit) begin @(negedge clk); #1; n++; end
        checks++;
        if (fd_cnt < 1) begin
            errors++; $display("FAIL wait_frame_done: got %0d pulses, required >= 1 within %0d clk", fd_cnt, limit);
        end
    endtask

    task automatic wait_bytes(input int nb, input int limit);
        int n = 0;
        while (bytes_q.size() < nb && n < limit) begin @(negedge clk); #1; n++; end
        checks++;
        if (bytes_q.size() < nb) begin
            errors++; $display("FAIL wait_bytes: got %0d bytes, required >= %0d", bytes_q.size(), nb);
        end
    endtask

    // Counts captured bytes that differ from the packing of the frame-buffer words.
    task automatic count_bad(input logic rgb, input logic sw, output int nbad);
        logic [11:0] w;
        logic [7:0]  e;
        nbad = 0;
        for (int i = 0; i < bytes_q.size(); i++) begin
            w = mem[(i / 2) % NPIX];
            if (!rgb) e = (i % 2 == 0) ? w[7:0] : 8'h80;
            else if (i % 2 == 0) e = {4'h0, sw ? w[3:0] : w[11:8]};
            else e = {w[7:4], sw ? w[11:8] : w[3:0]};
            if (bytes_q[i] !== e) nbad++;
        end
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < 64; i++) mem[i] = 12'(i * 291 + 12'h105);
    endtask

    task automatic fill_const(input logic [11:0] v);
        for (int i = 0; i < 64; i++) mem[i] = v;
    endtask

    task automatic run_frame(input logic rgb, input logic sw);
        mon_clear();
        rgbmode = rgb; swap_r_b = sw; enable = 1'b1;
        wait_vs(20);
        enable = 1'b0;
        wait_fd(FRAME_CLK + 50);
        repeat (8) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (pclk !== 1'b0) begin errors++; $display("FAIL reset_pclk: got %b want 0", pclk); end
        checks++; if (href !== 1'b0) begin errors++; $display("FAIL reset_href: got %b want 0", href); end
        checks++; if (vsync !== 1'b0) begin errors++; $display("FAIL reset_vsync: got %b want 0", vsync); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data); end
        checks++; if (addr !== 6'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", addr); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        mon_clear();
        rst = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        checks++; if (per_min != 4 || per_max != 4) begin errors++; $display("FAIL idle_pclk_period: got %0d..%0d want 4", per_min, per_max); end
        checks++; if (addr !== 6'd0) begin errors++; $display("FAIL idle_addr: got %0d want 0", addr); end
        checks++; if (vs_rises != 0) begin errors++; $display("FAIL idle_vsync: got %0d rises want 0", vs_rises); end
        checks++; if (bytes_q.size() != 0) begin errors++; $display("FAIL idle_href: got %0d bytes want 0", bytes_q.size()); end
    endtask

    task automatic test_frame_rgb();
        int nbl, nbg;
        fill_pattern();
        run_frame(1'b1, 1'b0);
        nbl = 0; nbg = 0;
        foreach (lines_q[i]) if (lines_q[i] != LINE_BYTES) nbl++;
        foreach (gaps_q[i]) if (gaps_q[i] != 16) nbg++;
        checks++; if (per_min != 4 || per_max != 4) begin errors++; $display("FAIL pclk_period: got %0d..%0d want 4", per_min, per_max); end
        checks++; if (vs_w_q.size() != 1 || vs_w_q[0] != 32) begin errors++; $display("FAIL vsync_width: got %0d pulses first %0d want 1 pulse of 32", vs_w_q.size(), (vs_w_q.size() > 0) ? vs_w_q[0] : -1); end
        checks++; if (lines_q.size() != ROWS) begin errors++; $display("FAIL href_count: got %0d want %0d", lines_q.size(), ROWS); end
        checks++; if (nbl != 0) begin errors++; $display("FAIL href_length: got %0d lines not %0d rises", nbl, LINE_BYTES); end
        checks++; if (gaps_q.size() != ROWS - 1 || nbg != 0) begin errors++; $display("FAIL hblank_gap: got %0d gaps %0d wrong want %0d of 16", gaps_q.size(), nbg, ROWS - 1); end
        checks++; if (fd_cyc - vs_start_cyc != FRAME_CLK) begin errors++; $display("FAIL frame_length: got %0d clk want %0d", fd_cyc - vs_start_cyc, FRAME_CLK); end
        checks++; if (fd_cnt != 1) begin errors++; $display("FAIL frame_done_pulse: got %0d clk high want 1", fd_cnt); end
        checks++; if (bytes_q.size() != 2 * NPIX) begin errors++; $display("FAIL byte_count: got %0d want %0d", bytes_q.size(), 2 * NPIX); end
        count_bad(1'b1, 1'b0, bad);
        checks++; if (bad != 0) begin errors++; $display("FAIL rgb_frame_data: got %0d wrong bytes want 0", bad); end
        checks++; if (nz_cnt != 0) begin errors++; $display("FAIL data_outside_href: got %0d nonzero samples want 0", nz_cnt); end
        checks++; if (max_addr != NPIX - 1) begin errors++; $display("FAIL max_addr: got %0d want %0d", max_addr, NPIX - 1); end
        checks++; if (addr !== 6'd0) begin errors++; $display("FAIL addr_wrap: got %0d want 0", addr); end
    endtask

    task automatic test_rgb_swap();
        fill_const(12'hABC);
        run_frame(1'b1, 1'b0);
        checks++; if (bytes_q.size() < 2 || bytes_q[0] !== 8'h0A) begin errors++; $display("FAIL rgb_byte0: got %h want 0a", (bytes_q.size() > 0) ? bytes_q[0] : 8'hxx); end
        checks++; if (bytes_q.size() < 2 || bytes_q[1] !== 8'hBC) begin errors++; $display("FAIL rgb_byte1: got %h want bc", (bytes_q.size() > 1) ? bytes_q[1] : 8'hxx); end
        run_frame(1'b1, 1'b1);
        checks++; if (bytes_q.size() < 2 || bytes_q[0] !== 8'h0C) begin errors++; $display("FAIL swap_byte0: got %h want 0c", (bytes_q.size() > 0) ? bytes_q[0] : 8'hxx); end
        checks++; if (bytes_q.size() < 2 || bytes_q[1] !== 8'hBA) begin errors++; $display("FAIL swap_byte1: got %h want ba", (bytes_q.size() > 1) ? bytes_q[1] : 8'hxx); end
        count_bad(1'b1, 1'b1, bad);
        checks++; if (bad != 0 || bytes_q.size() != 2 * NPIX) begin errors++; $display("FAIL swap_frame: got %0d wrong of %0d bytes want 0 of %0d", bad, bytes_q.size(), 2 * NPIX); end
    endtask

    task automatic test_yuv_latch();
        fill_const(12'h05A);
        mon_clear();
        rgbmode = 1'b0; swap_r_b = 1'b0; enable = 1'b1;
        wait_vs(20);
        enable = 1'b0;
        rgbmode = 1'b1; swap_r_b = 1'b1;
        wait_fd(FRAME_CLK + 50);
        repeat (8) @(negedge clk);
        #1;
        checks++; if (bytes_q.size() < 2 || bytes_q[0] !== 8'h5A) begin errors++; $display("FAIL yuv_byte0: got %h want 5a", (bytes_q.size() > 0) ? bytes_q[0] : 8'hxx); end
        checks++; if (bytes_q.size() < 2 || bytes_q[1] !== 8'h80) begin errors++; $display("FAIL yuv_byte1: got %h want 80", (bytes_q.size() > 1) ? bytes_q[1] : 8'hxx); end
        count_bad(1'b0, 1'b0, bad);
        checks++; if (bad != 0 || bytes_q.size() != 2 * NPIX) begin errors++; $display("FAIL yuv_mode_latched: got %0d wrong of %0d bytes want 0 of %0d", bad, bytes_q.size(), 2 * NPIX); end
        checks++; if (nz_cnt != 0) begin errors++; $display("FAIL yuv_data_outside_href: got %0d want 0", nz_cnt); end
    endtask

    task automatic test_enable_drop();
        int n;
        fill_pattern();
        mon_clear();
        rgbmode = 1'b1; swap_r_b = 1'b0; enable = 1'b1;
        n = 0;
        while (lines_q.size() < 3 && n < FRAME_CLK) begin @(negedge clk); #1; n++; end
        enable = 1'b0;
        wait_fd(FRAME_CLK);
        repeat (FRAME_CLK + 100) @(negedge clk);
        #1;
        checks++; if (lines_q.size() != ROWS) begin errors++; $display("FAIL drop_rows: got %0d want %0d", lines_q.size(), ROWS); end
        checks++; if (fd_cnt != 1) begin errors++; $display("FAIL drop_frame_done: got %0d want 1", fd_cnt); end
        checks++; if (vs_rises != 1) begin errors++; $display("FAIL drop_no_vsync: got %0d rises want 1", vs_rises); end
        checks++; if (addr !== 6'd0) begin errors++; $display("FAIL drop_idle_addr: got %0d want 0", addr); end
        mon_clear();
        enable = 1'b1;
        wait_bytes(2, 200);
        enable = 1'b0;
        checks++; if (bytes_q.size() < 2 || bytes_q[0] !== {4'h0, mem[0][11:8]} || bytes_q[1] !== mem[0][7:0]) begin
            errors++; $display("FAIL restart_addr0: got %h %h want %h %h", (bytes_q.size() > 0) ? bytes_q[0] : 8'hxx, (bytes_q.size() > 1) ? bytes_q[1] : 8'hxx, {4'h0, mem[0][11:8]}, mem[0][7:0]);
        end
        wait_fd(FRAME_CLK);
        repeat (8) @(negedge clk);
        #1;
    endtask

    task automatic test_reset_midframe();
        fill_pattern();
        mon_clear();
        rgbmode = 1'b1; swap_r_b = 1'b0; enable = 1'b1;
        wait_bytes(3 * LINE_BYTES + 2, FRAME_CLK);
        checks++; if (href !== 1'b1) begin errors++; $display("FAIL pre_reset_href: got %b want 1", href); end
        rst = 1'b0;
        #1;
        checks++; if (pclk !== 1'b0) begin errors++; $display("FAIL async_pclk: got %b want 0", pclk); end
        checks++; if (href !== 1'b0) begin errors++; $display("FAIL async_href: got %b want 0", href); end
        checks++; if (vsync !== 1'b0) begin errors++; $display("FAIL async_vsync: got %b want 0", vsync); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL async_data: got %h want 00", data); end
        checks++; if (addr !== 6'd0) begin errors++; $display("FAIL async_addr: got %0d want 0", addr); end
        mon_clear();
        rst = 1'b1;
        wait_vs(20);
        enable = 1'b0;
        wait_fd(FRAME_CLK + 50);
        repeat (8) @(negedge clk);
        #1;
        checks++; if (vs_rises != 1 || vs_w_q.size() < 1 || vs_w_q[0] != 32) begin errors++; $display("FAIL restart_vsync: got %0d rises width %0d want 1 of 32", vs_rises, (vs_w_q.size() > 0) ? vs_w_q[0] : -1); end
        count_bad(1'b1, 1'b0, bad);
        checks++; if (bad != 0 || bytes_q.size() != 2 * NPIX) begin errors++; $display("FAIL restart_frame: got %0d wrong of %0d bytes want 0 of %0d", bad, bytes_q.size(), 2 * NPIX); end
    endtask

    initial begin
        fill_pattern();
        test_reset();
        test_frame_rgb();
        test_rgb_swap();
        test_yuv_latch();
        test_enable_drop();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
